keypad_key_buffer: RTL and testbench
====================================

# keypad_key_buffer

Downstream consumer of the hex keypad scanner's `Code`/`Valid` outputs. It qualifies each key press and turns it into exactly one 4-bit key event per press, then queues events in a small first-word-fall-through FIFO. Software or a display stage drains the FIFO through a ready/valid handshake.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `STABLE_CYCLES`, default 4: consecutive equal samples needed to accept a press or a release; ≥2.
- `clock` input, 1 bit: sole clock; all logic is rising-edge.
- `reset` input, 1 bit: synchronous, active-high.
- `Code` input, 4 bits: key code from the scanner; meaningful only while `Valid`=1.
- `Valid` input, 1 bit: scanner key-detected flag; stays high while a key is held.
- `rd_data` output, 4 bits: FIFO head code; meaningful only while `rd_valid`=1.
- `rd_valid` output, 1 bit: FIFO non-empty.
- `rd_ready` input, 1 bit: consumer accepts head.
- `count` output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
- `full` output, 1 bit: `count`==DEPTH.
- `overflow` output, 1 bit: sticky; a qualified press was dropped because the FIFO was full.
- `overflow_clr` input, 1 bit: clears `overflow`.

## Operation
- Press FSM states: IDLE, QUALIFY, HELD, RELEASE.
- IDLE: when `Valid`=1, latch `Code`, set stable counter to 1, go to QUALIFY.
- QUALIFY: `Valid`=0 → IDLE, no push. `Code` differs from the latched code → relatch it, counter=1. Otherwise increment. When the counter reaches `STABLE_CYCLES`, push the latched code and go to HELD.
- HELD: ignore `Code` changes. When `Valid`=0, set release counter to 1 and go to RELEASE.
- RELEASE: `Valid`=1 → back to HELD, no push. Otherwise increment. When the counter reaches `STABLE_CYCLES`, go to IDLE.
- FIFO: pop when `rd_valid`&&`rd_ready`.
  - Push while full without a simultaneous pop → entry dropped and `overflow` set.
  - Push and pop in the same cycle while full → both take effect; `count` is unchanged and no overflow.
  - Push while empty → `rd_valid` goes high; that cycle never pops.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `overflow`: a set event in the same cycle as `overflow_clr` wins.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `count`=0, `full`=0, `overflow`=0, FSM=IDLE, pointers=0.
- Press latency: first edge sampling `Valid`=1 is edge k. With stable `Code`, the push occurs at edge k+`STABLE_CYCLES`-1, and `rd_valid`/`rd_data` show the entry after that edge.
- Pop: `rd_data` shows the next entry, or `rd_valid` drops, after the accepting edge.
- `full`, `count` and `overflow` update on the same edge as the push or pop.
- Reset mid-press: the FSM returns to IDLE. If the key is still held after reset, it is re-qualified and pushed again.
- Reset clears the FIFO contents.

## Configuration
- `KEYPAD_DEBOUNCE_EN` defined: the QUALIFY/RELEASE behaviour described above.
- `KEYPAD_DEBOUNCE_EN` not defined: no stable counters; `STABLE_CYCLES` is unused.
  - A registered copy of `Valid` drives detection.
  - The push happens at edge k, the first edge sampling `Valid`=1 after a sample of 0, with the `Code` sampled at that edge.
  - Every 0→1 transition of `Valid` produces one push, glitches included.

## Structure
- Shared package `keypad_pkg`:
  - FSM state enum.
  - `KEY_CODE_W`=4.
  - Default constants for `DEPTH` and `STABLE_CYCLES`.
- Sub-module `keypad_code_fifo`: parameterised FWFT FIFO with push/pop/full/count/overflow.
- The top level holds the press FSM and instantiates `keypad_code_fifo`.

## Test plan
Defaults for all scenarios: `DEPTH`=8, `STABLE_CYCLES`=4, `KEYPAD_DEBOUNCE_EN` defined.
- Clean press: `Valid`=1 with `Code`=4'h5 held for 60 cycles, then released → exactly one entry 4'h5. `rd_valid` rises after edge k+3; `count`=1.
- Bounce: `Valid` high 2 cycles, low 1, then high 10 cycles with `Code`=4'hA → exactly one push of 4'hA, 4 cycles after the final rise.
- Code change during qualify: `Code` 4'h3 for 2 cycles, then 4'h7 held → single entry 4'h7; no 4'h3 entry.
- Overflow: 9 presses 4'h0..4'h8 with `rd_ready`=0 → `count`=8, `full`=1, `overflow`=1. Draining yields 4'h0..4'h7. `overflow_clr` then clears the flag.
- Simultaneous push and pop while full: `rd_ready`=1 on the push edge → `count` stays 8 and `overflow` stays 0. Pop order is preserved across pointer wrap.
- Reset mid-press: `reset` pulsed in HELD while `Valid` stays 1 with `Code`=4'hC → all outputs zero after reset, then one new 4'hC entry 4 cycles later.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad key buffer slice: the key-code width,
// default sizing constants and the press-qualification FSM state type.
package keypad_pkg;

   localparam int KEY_CODE_W            = 4;
   localparam int DEFAULT_DEPTH         = 8;
   localparam int DEFAULT_STABLE_CYCLES = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_QUALIFY,
      ST_HELD,
      ST_RELEASE
   } press_state_e;

endpackage

// File: rtl/keypad_code_fifo.sv
// keypad_code_fifo
// First-word-fall-through FIFO of key codes with a sticky overflow flag.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   push_i, push_data_i - write request and the code to store
//   pop_ready_i         - consumer accepts the head entry (pops when non-empty)
//   overflow_clr_i      - clears the sticky overflow flag
//   rd_data_o           - head entry (zero while empty)
//   rd_valid_o          - FIFO non-empty
//   count_o             - occupancy 0..DEPTH
//   full_o              - occupancy equals DEPTH
//   overflow_o          - a push was dropped because the FIFO was full
module keypad_code_fifo
   import keypad_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    push_i,
   input  logic [KEY_CODE_W-1:0]   push_data_i,
   input  logic                    pop_ready_i,
   input  logic                    overflow_clr_i,
   output logic [KEY_CODE_W-1:0]   rd_data_o,
   output logic                    rd_valid_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    full_o,
   output logic                    overflow_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [KEY_CODE_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;

   logic empty;
   logic pop;
   logic pushAccept;
   logic overflowSet;

   // A push into a full FIFO is still accepted when a pop frees the head slot
   // on the same edge; pop is qualified by non-empty so an empty FIFO never pops.
   always_comb begin
      empty       = (count_q == '0);
      full_o      = (count_q == CNT_W'(DEPTH));
      pop         = !empty && pop_ready_i;
      pushAccept  = push_i && (!full_o || pop);
      overflowSet = push_i && full_o && !pop;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (pushAccept) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (pushAccept && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!pushAccept && pop) begin
         count_d = count_q - CNT_W'(1);
      end

      // A set event beats a clear arriving on the same edge.
      if (overflowSet) begin
         overflow_d = 1'b1;
      end else if (overflow_clr_i) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (pushAccept) begin
            mem_q[wr_ptr_q] <= push_data_i;
         end
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign rd_valid_o = !empty;
   assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/keypad_key_buffer.sv
// keypad_key_buffer
// Turns the keypad scanner's Code/Valid stream into one key event per press
// and queues the events in a first-word-fall-through FIFO.
// Build option: define KEYPAD_DEBOUNCE_EN to qualify presses and releases
// with STABLE_CYCLES consecutive equal samples; otherwise every 0->1 edge of
// a registered copy of Valid pushes the Code sampled on that edge.
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   Code, Valid    - scanner key code and key-detected flag
//   rd_data        - FIFO head code (zero while empty)
//   rd_valid       - FIFO non-empty
//   rd_ready       - consumer accepts the head entry
//   count, full    - FIFO occupancy and full flag
//   overflow       - sticky: a qualified press was dropped while full
//   overflow_clr   - clears overflow
module keypad_key_buffer
   import keypad_pkg::*;
#(
   parameter int DEPTH         = DEFAULT_DEPTH,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [KEY_CODE_W-1:0]   Code,
   input  logic                    Valid,
   output logic [KEY_CODE_W-1:0]   rd_data,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    overflow,
   input  logic                    overflow_clr
);

   logic                  push;
   logic [KEY_CODE_W-1:0] pushCode;

`ifdef KEYPAD_DEBOUNCE_EN

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

   press_state_e          state_q, state_d;
   logic [KEY_CODE_W-1:0] code_q, code_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   // One counter serves both qualification phases: it counts equal Valid=1
   // samples in QUALIFY and consecutive Valid=0 samples in RELEASE. The
   // push fires on the edge whose sample would bring the count to
   // STABLE_CYCLES, so a clean press lands STABLE_CYCLES-1 edges after the
   // first Valid=1 sample.
   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      cnt_d    = cnt_q;
      push     = 1'b0;
      pushCode = code_q;

      case (state_q)
         ST_IDLE: begin
            if (Valid) begin
               code_d  = Code;
               cnt_d   = CNT_W'(1);
               state_d = ST_QUALIFY;
            end
         end
         ST_QUALIFY: begin
            if (!Valid) begin
               state_d = ST_IDLE;
            end else if (Code != code_q) begin
               code_d = Code;
               cnt_d  = CNT_W'(1);
            end else if (int'(cnt_q) + 1 == STABLE_CYCLES) begin
               push    = 1'b1;
               state_d = ST_HELD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HELD: begin
            if (!Valid) begin
               cnt_d   = CNT_W'(1);
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (Valid) begin
               state_d = ST_HELD;
            end else if (int'(cnt_q) + 1 == STABLE_CYCLES) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         code_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
      end
   end

`else

   logic        valid_q;
   logic [31:0] unusedStableCycles;

   // Without debouncing the only memory is last cycle's Valid; a rising edge
   // of Valid pushes the Code present on that same edge.
   always_comb begin
      push     = Valid && !valid_q;
      pushCode = Code;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= Valid;
      end
   end

   assign unusedStableCycles = STABLE_CYCLES;

`endif

   keypad_code_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock          (clock),
      .reset          (reset),
      .push_i         (push),
      .push_data_i    (pushCode),
      .pop_ready_i    (rd_ready),
      .overflow_clr_i (overflow_clr),
      .rd_data_o      (rd_data),
      .rd_valid_o     (rd_valid),
      .count_o        (count),
      .full_o         (full),
      .overflow_o     (overflow)
   );

endmodule

// File: tb/tb_keypad_key_buffer.sv
// tb_keypad_key_buffer
// Drives directed press scenarios followed by a randomized Valid/Code stream
// into keypad_key_buffer and compares every output after every edge with a
// behavioural model (press detection by run lengths, FIFO as a queue).
module tb_keypad_key_buffer;

   localparam int DEPTH  = 8;
   localparam int STABLE = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] Code;
   logic       Valid;
   logic [3:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic [3:0] count;
   logic       full;
   logic       overflow;
   logic       overflow_clr;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   int         armed;
   int         runLen;
   int         runCode;
   int         lowRun;
   int         prevValid;
   logic [3:0] mq[$];
   int         mOvf;

   always #5 clock = ~clock;

   keypad_key_buffer #(
      .DEPTH         (DEPTH),
      .STABLE_CYCLES (STABLE)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .Code         (Code),
      .Valid        (Valid),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .count        (count),
      .full         (full),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      if (observed != expected) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, observed, expected);
      end
   endtask

   // Model update for one rising edge, using the inputs present at that edge.
   task automatic modelStep();
      int pushEv;
      int pushVal;
      int popEv;
      pushEv  = 0;
      pushVal = 0;
      if (reset) begin
         armed     = 1;
         runLen    = 0;
         runCode   = 0;
         lowRun    = 0;
         prevValid = 0;
         mq.delete();
         mOvf      = 0;
         return;
      end
`ifdef KEYPAD_DEBOUNCE_EN
      // Armed: a press is STABLE consecutive Valid=1 samples of one code.
      // Disarmed: STABLE consecutive Valid=0 samples re-arm.
      if (armed != 0) begin
         if (Valid) begin
            if (runLen > 0 && int'(Code) == runCode) begin
               runLen++;
            end else begin
               runCode = int'(Code);
               runLen  = 1;
            end
            if (runLen == STABLE) begin
               pushEv  = 1;
               pushVal = runCode;
               armed   = 0;
               lowRun  = 0;
            end
         end else begin
            runLen = 0;
         end
      end else begin
         if (!Valid) begin
            lowRun++;
            if (lowRun == STABLE) begin
               armed  = 1;
               runLen = 0;
            end
         end else begin
            lowRun = 0;
         end
      end
`else
      if (Valid && prevValid == 0) begin
         pushEv  = 1;
         pushVal = int'(Code);
      end
      prevValid = Valid ? 1 : 0;
`endif
      popEv = (mq.size() != 0 && rd_ready) ? 1 : 0;
      if (pushEv != 0 && mq.size() == DEPTH && popEv == 0) begin
         mOvf = 1;
      end else if (overflow_clr) begin
         mOvf = 0;
      end
      if (popEv != 0) begin
         void'(mq.pop_front());
      end
      if (pushEv != 0 && mq.size() < DEPTH) begin
         mq.push_back(4'(pushVal));
      end
   endtask

   // Apply one cycle of inputs, clock it, update the model, then compare.
   task automatic applyStimulus(input logic v, input logic [3:0] c, input logic rdy,
                                input logic clr, input logic rst);
      Valid        = v;
      Code         = c;
      rd_ready     = rdy;
      overflow_clr = clr;
      reset        = rst;
      @(posedge clock);
      modelStep();
      #1;
      checkOutput("rd_valid", int'(rd_valid), (mq.size() != 0) ? 1 : 0);
      checkOutput("rd_data", int'(rd_data), (mq.size() != 0) ? int'(mq[0]) : 0);
      checkOutput("count", int'(count), mq.size());
      checkOutput("full", int'(full), (mq.size() == DEPTH) ? 1 : 0);
      checkOutput("overflow", int'(overflow), mOvf);
   endtask

   task automatic holdInputs(input logic v, input logic [3:0] c, input logic rdy, input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(v, c, rdy, 1'b0, 1'b0);
      end
   endtask

   task automatic drain();
      holdInputs(1'b0, 4'h0, 1'b1, DEPTH + 4);
   endtask

   initial begin
      Valid        = 1'b0;
      Code         = 4'h0;
      rd_ready     = 1'b0;
      overflow_clr = 1'b0;
      reset        = 1'b1;
      armed        = 1;
      runLen       = 0;
      runCode      = 0;
      lowRun       = 0;
      prevValid    = 0;
      mOvf         = 0;

      // Reset state
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      holdInputs(1'b0, 4'h0, 1'b0, 3);

      // Clean press, long hold
      holdInputs(1'b1, 4'h5, 1'b0, 60);
      holdInputs(1'b0, 4'h0, 1'b0, 8);
      drain();

      // Bounce then steady press
      holdInputs(1'b1, 4'hA, 1'b0, 2);
      holdInputs(1'b0, 4'hA, 1'b0, 1);
      holdInputs(1'b1, 4'hA, 1'b0, 10);
      holdInputs(1'b0, 4'h0, 1'b0, 8);
      drain();

      // Code change while qualifying
      holdInputs(1'b1, 4'h3, 1'b0, 2);
      holdInputs(1'b1, 4'h7, 1'b0, 10);
      holdInputs(1'b0, 4'h0, 1'b0, 8);
      drain();

      // Overflow: nine presses with no reads, drain, clear flag
      for (int k = 0; k < 9; k++) begin
         holdInputs(1'b1, 4'(k), 1'b0, 6);
         holdInputs(1'b0, 4'h0, 1'b0, 6);
      end
      drain();
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      holdInputs(1'b0, 4'h0, 1'b0, 2);

      // Push and pop on the same edge while full
      for (int k = 0; k < DEPTH; k++) begin
         holdInputs(1'b1, 4'(k + 8), 1'b0, 6);
         holdInputs(1'b0, 4'h0, 1'b0, 6);
      end
      holdInputs(1'b1, 4'h1, 1'b0, STABLE - 1);
      holdInputs(1'b1, 4'h1, 1'b1, 1);
      holdInputs(1'b1, 4'h1, 1'b0, 4);
      holdInputs(1'b0, 4'h0, 1'b0, 6);
      drain();

      // Reset while the key is held
      holdInputs(1'b1, 4'hC, 1'b0, 10);
      applyStimulus(1'b1, 4'hC, 1'b0, 1'b0, 1'b1);
      holdInputs(1'b1, 4'hC, 1'b0, 10);
      holdInputs(1'b0, 4'h0, 1'b0, 8);
      drain();

      // Randomized segments of held / released input
      for (int s = 0; s < 400; s++) begin
         logic       v;
         logic [3:0] c;
         int         len;
         v   = ($urandom_range(0, 1) == 1);
         c   = 4'($urandom_range(0, 15));
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 16) : $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 9) == 0) begin
               c = 4'($urandom_range(0, 15));
            end
            applyStimulus(v, c, ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 299) == 0));
         end
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
